lcd_bus_scheduler: RTL and testbench

Owns the HD44780-style 8-bit character LCD bus and shares it between two byte-stream requesters. Requester 0 is the text source, for example the Morse decoder character output. Requester 1 is the control source, for example clear, home and cursor commands from the UI logic. After reset the block runs the power-on init sequence itself, then round-robin arbitrates byte requests and generates E pulses with per-command execution delays. It tracks the cursor and automatically wraps 16x2 lines.

---
 rtl/lcd_pkg.sv | 52 +++++
 rtl/lcd_byte_strobe.sv | 102 ++++++++++
 rtl/lcd_bus_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the power-on init ROM for the
// character-LCD bus scheduler.
package lcd_pkg;

    localparam int CNT_W = 20;

    localparam int E_PULSE_DEF   = 20;
    localparam int CNT_15MS_DEF  = 750_000;
    localparam int CNT_5MS_DEF   = 250_000;
    localparam int CNT_100US_DEF = 5_000;
    localparam int CNT_CMD_DEF   = 2_500;
    localparam int CNT_CLR_DEF   = 100_000;
    localparam int COLS_DEF      = 16;

    localparam logic [7:0] WAKEUP   = 8'h30;
    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_OFF = 8'h08;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] HOME     = 8'h02;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] LINE0    = 8'h80;
    localparam logic [7:0] LINE1    = 8'hC0;

    typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_XFER, S_WRAP} state_t;
    typedef enum logic [1:0] {P_IDLE, P_SETUP, P_HIGH, P_WAIT} phase_t;
    typedef enum logic [1:0] {W_5MS, W_100US, W_CMD, W_CLR} wait_sel_t;

    typedef struct packed {
        logic [7:0] data;
        wait_sel_t  wsel;
    } init_entry_t;

    function automatic init_entry_t init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{data: WAKEUP,   wsel: W_5MS};
            3'd1:    return '{data: WAKEUP,   wsel: W_100US};
            3'd2:    return '{data: WAKEUP,   wsel: W_CMD};
            3'd3:    return '{data: FUNC_SET, wsel: W_CMD};
            3'd4:    return '{data: DISP_OFF, wsel: W_CMD};
            3'd5:    return '{data: CLEAR,    wsel: W_CLR};
            3'd6:    return '{data: ENTRY,    wsel: W_CMD};
            default: return '{data: DISP_ON,  wsel: W_CMD};
        endcase
    endfunction

    // Clear, home and the undocumented 0x03 alias all need the long wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CLEAR || data == HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_byte_strobe.sv
// One LCD byte cycle: latch rs/data onto the bus, raise E for E_PULSE clocks
// one cycle later, then hold E low for the latched wait count and pulse done.
module lcd_byte_strobe
    import lcd_pkg::*;
#(
    parameter int E_PULSE = E_PULSE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rs,
    input  logic [7:0]       data,
    input  logic [CNT_W-1:0] wait_cnt,
    output logic             lcd_rs,
    output logic             lcd_e,
    output logic [7:0]       lcd_data,
    output logic             done
);

    localparam logic [CNT_W:0] E_LEN = (CNT_W + 1)'(E_PULSE);

    phase_t           phase_reg, phase_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] wait_reg, wait_next;
    logic             rs_reg, rs_next;
    logic [7:0]       data_reg, data_next;
    logic             e_reg, e_next;
    logic             done_reg, done_next;
    logic [CNT_W:0]   cnt_inc;

    assign cnt_inc  = {1'b0, cnt_reg} + (CNT_W + 1)'(1);
    assign lcd_rs   = rs_reg;
    assign lcd_e    = e_reg;
    assign lcd_data = data_reg;
    assign done     = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= P_IDLE;
            cnt_reg   <= '0;
            wait_reg  <= '0;
            rs_reg    <= 1'b0;
            data_reg  <= 8'h00;
            e_reg     <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            wait_reg  <= wait_next;
            rs_reg    <= rs_next;
            data_reg  <= data_next;
            e_reg     <= e_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        wait_next  = wait_reg;
        rs_next    = rs_reg;
        data_next  = data_reg;
        e_next     = e_reg;
        done_next  = 1'b0;
        case (phase_reg)
            P_IDLE: begin
                if (start) begin
                    rs_next    = rs;
                    data_next  = data;
                    wait_next  = wait_cnt;
                    phase_next = P_SETUP;
                end
            end
            // Bus has been stable for one clock; E rises now.
            P_SETUP: begin
                e_next     = 1'b1;
                cnt_next   = '0;
                phase_next = P_HIGH;
            end
            P_HIGH: begin
                if (cnt_inc >= E_LEN) begin
                    e_next     = 1'b0;
                    cnt_next   = '0;
                    phase_next = P_WAIT;
                end else begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                end
            end
            P_WAIT: begin
                if (cnt_inc >= {1'b0, wait_reg}) begin
                    done_next  = 1'b1;
                    cnt_next   = '0;
                    phase_next = P_IDLE;
                end else begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                end
            end
            default: phase_next = P_IDLE;
        endcase
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Owns the 8-bit HD44780 bus: runs power-on init, then round-robin arbitrates
// two byte requesters, tracks the cursor and inserts line-wrap commands.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int E_PULSE   = E_PULSE_DEF,
    parameter int CNT_15MS  = CNT_15MS_DEF,
    parameter int CNT_5MS   = CNT_5MS_DEF,
    parameter int CNT_100US = CNT_100US_DEF,
    parameter int CNT_CMD   = CNT_CMD_DEF,
    parameter int CNT_CLR   = CNT_CLR_DEF,
    parameter int COLS      = COLS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       busy
);

    localparam int COL_W = $clog2(COLS + 1);
    localparam logic [CNT_W:0] PWR_LEN = (CNT_W + 1)'(CNT_15MS);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] pwr_cnt_reg, pwr_cnt_next;
    logic [2:0]       init_idx_reg, init_idx_next;
    logic             active_reg, active_next;
    logic             wrap_reg, wrap_next;
    logic             init_done_reg, init_done_next;
    logic             rr_reg, rr_next;
    logic             line_reg, line_next;
    logic [COL_W-1:0] col_reg, col_next;

    logic             bs_start, bs_rs, bs_done;
    logic [7:0]       bs_data;
    logic [CNT_W-1:0] bs_wait;
    logic             grant0, grant1;
    logic             sel_rs;
    logic [7:0]       sel_data;
    logic [COL_W-1:0] col_inc;
    logic [CNT_W:0]   pwr_inc;
    init_entry_t      init_entry;

    function automatic logic [CNT_W-1:0] wait_count(input wait_sel_t w);
        case (w)
            W_5MS:   return CNT_W'(CNT_5MS);
            W_100US: return CNT_W'(CNT_100US);
            W_CLR:   return CNT_W'(CNT_CLR);
            default: return CNT_W'(CNT_CMD);
        endcase
    endfunction

    assign init_entry = init_rom(init_idx_reg);
    assign grant0     = req0_valid && (!req1_valid || !rr_reg);
    assign grant1     = req1_valid && (!req0_valid || rr_reg);
    assign sel_rs     = grant1 ? req1_rs : req0_rs;
    assign sel_data   = grant1 ? req1_data : req0_data;
    assign col_inc    = col_reg + COL_W'(1);
    assign pwr_inc    = {1'b0, pwr_cnt_reg} + (CNT_W + 1)'(1);

    assign lcd_rw    = 1'b0;
    assign init_done = init_done_reg;
    assign busy      = (state_reg != S_IDLE);

    lcd_byte_strobe #(
        .E_PULSE (E_PULSE)
    ) u_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (bs_start),
        .rs       (bs_rs),
        .data     (bs_data),
        .wait_cnt (bs_wait),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .done     (bs_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_PWR;
            pwr_cnt_reg   <= '0;
            init_idx_reg  <= '0;
            active_reg    <= 1'b0;
            wrap_reg      <= 1'b0;
            init_done_reg <= 1'b0;
            rr_reg        <= 1'b0;
            line_reg      <= 1'b0;
            col_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pwr_cnt_reg   <= pwr_cnt_next;
            init_idx_reg  <= init_idx_next;
            active_reg    <= active_next;
            wrap_reg      <= wrap_next;
            init_done_reg <= init_done_next;
            rr_reg        <= rr_next;
            line_reg      <= line_next;
            col_reg       <= col_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pwr_cnt_next   = pwr_cnt_reg;
        init_idx_next  = init_idx_reg;
        active_next    = active_reg;
        wrap_next      = wrap_reg;
        init_done_next = init_done_reg;
        rr_next        = rr_reg;
        line_next      = line_reg;
        col_next       = col_reg;
        bs_start       = 1'b0;
        bs_rs          = 1'b0;
        bs_data        = 8'h00;
        bs_wait        = '0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        case (state_reg)
            S_PWR: begin
                if (pwr_inc >= PWR_LEN) begin
                    pwr_cnt_next  = '0;
                    init_idx_next = '0;
                    active_next   = 1'b0;
                    state_next    = S_INIT;
                end else begin
                    pwr_cnt_next = pwr_inc[CNT_W-1:0];
                end
            end
            // active_reg marks a ROM byte handed to the strobe and not yet done.
            S_INIT: begin
                if (!active_reg) begin
                    bs_start    = 1'b1;
                    bs_data     = init_entry.data;
                    bs_wait     = wait_count(init_entry.wsel);
                    active_next = 1'b1;
                end else if (bs_done) begin
                    active_next = 1'b0;
                    if (init_idx_reg == 3'd7) begin
                        init_done_next = 1'b1;
                        state_next     = S_IDLE;
                    end else begin
                        init_idx_next = init_idx_reg + 3'd1;
                    end
                end
            end
            S_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    bs_start   = 1'b1;
                    bs_rs      = sel_rs;
                    bs_data    = sel_data;
                    bs_wait    = is_slow_cmd(sel_rs, sel_data) ? wait_count(W_CLR)
                                                               : wait_count(W_CMD);
                    state_next = S_XFER;
                    if (req0_valid && req1_valid) begin
                        rr_next = !rr_reg;
                    end
                    if (is_slow_cmd(sel_rs, sel_data)) begin
                        col_next  = '0;
                        line_next = 1'b0;
                    end else if (!sel_rs && sel_data[7]) begin
                        col_next  = COL_W'(sel_data[3:0]);
                        line_next = sel_data[6];
                    end else if (sel_rs) begin
                        col_next  = col_inc;
                        wrap_next = (int'(col_inc) >= COLS);
                    end
                end
            end
            S_XFER: begin
                if (bs_done) begin
                    state_next = wrap_reg ? S_WRAP : S_IDLE;
                end
            end
            S_WRAP: begin
                if (!active_reg) begin
                    bs_start    = 1'b1;
                    bs_data     = line_reg ? LINE0 : LINE1;
                    bs_wait     = wait_count(W_CMD);
                    active_next = 1'b1;
                end else if (bs_done) begin
                    active_next = 1'b0;
                    wrap_next   = 1'b0;
                    line_next   = !line_reg;
                    col_next    = '0;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_PWR;
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench: captures every E pulse on the LCD bus and compares it
// with a byte-stream reference model of init, arbitration and line wrapping.
module tb_lcd_bus_scheduler;

    localparam int TE    = 4;
    localparam int T15   = 200;
    localparam int T5    = 80;
    localparam int T100  = 30;
    localparam int TCMD  = 12;
    localparam int TCLR  = 50;
    localparam int TCOLS = 16;
    localparam int TMO   = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_ready;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_ready;
    logic [7:0] req1_data = 8'h00;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, busy;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_bus_scheduler #(
        .E_PULSE(TE), .CNT_15MS(T15), .CNT_5MS(T5), .CNT_100US(T100),
        .CNT_CMD(TCMD), .CNT_CLR(TCLR), .COLS(TCOLS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
        .init_done(init_done), .busy(busy)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
        int         width;
    } pulse_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wt;
    } exp_t;

    pulse_t cap[$];
    exp_t   expq[$];

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int m_col = 0, m_line = 0, m_rr = 0;

    logic [7:0] init_bytes [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    int         init_waits [8] = '{T5, T100, TCMD, TCMD, TCMD, TCLR, TCMD, TCMD};

    // Bus monitor
    logic       e_prev = 1'b0, id_prev = 1'b0;
    logic       cur_rs = 1'b0;
    logic [7:0] cur_data = 8'h00;
    int         rise_cyc = 0, init_rise_cyc = 0;
    int         bad_cnt = 0, both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            rise_cyc <= cyc;
            cur_rs   <= lcd_rs;
            cur_data <= lcd_data;
        end
        if (!lcd_e && e_prev) cap.push_back('{cur_rs, cur_data, rise_cyc, cyc - rise_cyc});
        e_prev <= lcd_e;
        if (init_done && !id_prev) init_rise_cyc <= cyc;
        id_prev <= init_done;
        if ((req0_ready || req1_ready) && (!init_done || busy)) bad_cnt <= bad_cnt + 1;
        if (req0_ready && req1_ready) both_cnt <= both_cnt + 1;
    end

    // Reference model: what the bus must carry, derived from accepted bytes.
    function automatic void model_init();
        expq.delete();
        m_col = 0; m_line = 0; m_rr = 0;
        for (int i = 0; i < 8; i++) expq.push_back('{1'b0, init_bytes[i], init_waits[i]});
    endfunction

    function automatic void model_accept(input logic rs, input logic [7:0] d);
        logic slow;
        slow = !rs && (d >= 8'h01) && (d <= 8'h03);
        expq.push_back('{rs, d, slow ? TCLR : TCMD});
        if (slow) begin
            m_col = 0; m_line = 0;
        end else if (!rs && d[7]) begin
            m_col = int'(d[3:0]); m_line = int'(d[6]);
        end else if (rs) begin
            m_col++;
            if (m_col == TCOLS) begin
                expq.push_back('{1'b0, (m_line != 0) ? 8'h80 : 8'hC0, TCMD});
                m_line = 1 - m_line;
                m_col = 0;
            end
        end
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < TMO);
        n_vec++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL %s idle timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    task automatic check_pulses(input string tag);
        exp_t   e;
        pulse_t p;
        int     have_prev, prev_rise, prev_wt;
        have_prev = 0; prev_rise = 0; prev_wt = 0;
        wait_idle(tag);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_vec++;
            if (cap.size() == 0) begin
                n_mis++;
                $display("FAIL %s missing pulse: got none, required rs=%0d data=%02h", tag, e.rs, e.data);
            end else begin
                p = cap.pop_front();
                $display("%s pulse rs=%0d data=%02h width=%0d rise=%0d", tag, p.rs, p.data, p.width, p.rise);
                if (p.rs !== e.rs || p.data !== e.data || p.width != TE) begin
                    n_mis++;
                    $display("FAIL %s pulse: got rs=%0d data=%02h width=%0d, required rs=%0d data=%02h width=%0d",
                             tag, p.rs, p.data, p.width, e.rs, e.data, TE);
                end
                if (have_prev != 0) begin
                    n_vec++;
                    if (p.rise - prev_rise < TE + prev_wt) begin
                        n_mis++;
                        $display("FAIL %s spacing: got %0d clocks, required >= %0d", tag, p.rise - prev_rise, TE + prev_wt);
                    end
                end
                have_prev = 1; prev_rise = p.rise; prev_wt = e.wt;
            end
        end
        n_vec++;
        if (cap.size() != 0) begin
            n_mis++;
            $display("FAIL %s extra pulses: got %0d unexpected, required 0", tag, cap.size());
        end
        cap.delete();
    endtask

    task automatic do_xfer(input int who, input logic rs, input logic [7:0] d);
        int   n;
        logic got;
        n = 0; got = 1'b0;
        @(posedge clk); #1;
        if (who == 0) begin req0_valid = 1'b1; req0_rs = rs; req0_data = d; end
        else          begin req1_valid = 1'b1; req1_rs = rs; req1_data = d; end
        while (!got && n < TMO) begin
            @(negedge clk);
            n++;
            got = (who == 0) ? req0_ready : req1_ready;
        end
        n_vec++;
        if (!got) begin
            n_mis++;
            $display("FAIL xfer ready timeout: req%0d ready=0 after %0d cycles, required 1", who, n);
        end else begin
            @(posedge clk);
            model_accept(rs, d);
            $display("xfer req%0d rs=%0d data=%02h col=%0d line=%0d", who, rs, d, m_col, m_line);
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'($urandom); req1_data = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        n_vec += 9;
        if (lcd_rs !== 1'b0)      begin n_mis++; $display("FAIL reset lcd_rs: got %b required 0", lcd_rs); end
        if (lcd_rw !== 1'b0)      begin n_mis++; $display("FAIL reset lcd_rw: got %b required 0", lcd_rw); end
        if (lcd_e !== 1'b0)       begin n_mis++; $display("FAIL reset lcd_e: got %b required 0", lcd_e); end
        if (lcd_data !== 8'h00)   begin n_mis++; $display("FAIL reset lcd_data: got %02h required 00", lcd_data); end
        if (req0_ready !== 1'b0)  begin n_mis++; $display("FAIL reset req0_ready: got %b required 0", req0_ready); end
        if (req1_ready !== 1'b0)  begin n_mis++; $display("FAIL reset req1_ready: got %b required 0", req1_ready); end
        if (init_done !== 1'b0)   begin n_mis++; $display("FAIL reset init_done: got %b required 0", init_done); end
        if (busy !== 1'b1)        begin n_mis++; $display("FAIL reset busy: got %b required 1", busy); end
        if (dut.u_strobe.lcd_e !== lcd_e) begin n_mis++; $display("FAIL reset strobe_e: got %b required %b", dut.u_strobe.lcd_e, lcd_e); end
        cap.delete();
        model_init();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rel_cyc = cyc;
        $display("reset released at cycle %0d", rel_cyc);
    endtask

    task automatic test_init(input string tag);
        int n, first_rise, last_fall;
        n = 0;
        while (!init_done && n < TMO) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (init_done !== 1'b1) begin
            n_mis++;
            $display("FAIL %s init_done timeout: got %b, required 1", tag, init_done);
        end
        wait_idle(tag);
        first_rise = (cap.size() > 0) ? cap[0].rise : rel_cyc - 1;
        last_fall  = (cap.size() > 0) ? cap[$].rise + cap[$].width : init_rise_cyc + 1;
        n_vec++;
        if (first_rise - rel_cyc < T15) begin
            n_mis++;
            $display("FAIL %s power-on wait: got %0d clocks, required >= %0d", tag, first_rise - rel_cyc, T15);
        end
        n_vec++;
        if (init_rise_cyc - last_fall < TCMD) begin
            n_mis++;
            $display("FAIL %s init_done timing: got %0d clocks after last E, required >= %0d", tag, init_rise_cyc - last_fall, TCMD);
        end
        n_vec++;
        if (bad_cnt != 0) begin
            n_mis++;
            $display("FAIL %s ready outside idle: got %0d cycles, required 0", tag, bad_cnt);
        end
        check_pulses(tag);
    endtask

    task automatic test_hi();
        do_xfer(0, 1'b1, 8'h48);
        do_xfer(0, 1'b1, 8'h49);
        check_pulses("hi");
    endtask

    task automatic test_wrap();
        do_xfer(1, 1'b0, 8'h01);
        for (int i = 0; i < 16; i++) do_xfer(0, 1'b1, 8'h61 + 8'(i));
        check_pulses("wrap_line0");
        for (int i = 0; i < 16; i++) do_xfer(0, 1'b1, 8'h41 + 8'(i));
        check_pulses("wrap_line1");
    endtask

    task automatic test_clear_midline();
        for (int i = 0; i < 5; i++) do_xfer(0, 1'b1, 8'h30 + 8'(i));
        do_xfer(1, 1'b0, 8'h01);
        for (int i = 0; i < 17; i++) do_xfer(0, 1'b1, 8'h50 + 8'(i));
        check_pulses("clear_midline");
    endtask

    task automatic test_back_to_back(input int n_grants);
        int g, n, who, both_base;
        g = 0; n = 0; both_base = both_cnt;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h0C;
        while (g < n_grants && n < TMO * n_grants) begin
            @(negedge clk);
            n++;
            if (req0_ready || req1_ready) begin
                who = req1_ready ? 1 : 0;
                n_vec++;
                $display("grant %0d to req%0d", g, who);
                if (who != m_rr) begin
                    n_mis++;
                    $display("FAIL rr grant %0d: got req%0d, required req%0d", g, who, m_rr);
                end
                if (who == 0) model_accept(1'b1, 8'h41);
                else          model_accept(1'b0, 8'h0C);
                m_rr = 1 - m_rr;
                g++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_vec++;
        if (g != n_grants) begin
            n_mis++;
            $display("FAIL rr grant count: got %0d, required %0d", g, n_grants);
        end
        check_pulses("back_to_back");
        n_vec++;
        if (both_cnt != both_base) begin
            n_mis++;
            $display("FAIL dual ready: got %0d cycles with both high, required 0", both_cnt - both_base);
        end
    endtask

    task automatic test_random(input int n_tx);
        logic [7:0] cmds [6] = '{8'h01, 8'h02, 8'h0C, 8'h06, 8'h10, 8'h38};
        int who;
        logic rs;
        logic [7:0] d;
        for (int i = 0; i < n_tx; i++) begin
            who = int'($urandom_range(1, 0));
            rs  = ($urandom_range(3, 0) != 0);
            if (rs) d = 8'h20 + 8'($urandom_range(63, 0));
            else begin
                case ($urandom_range(2, 0))
                    0:       d = cmds[$urandom_range(5, 0)];
                    1:       d = 8'h80 | 8'($urandom_range(15, 0));
                    default: d = 8'hC0 | 8'($urandom_range(15, 0));
                endcase
            end
            do_xfer(who, rs, d);
        end
        check_pulses("random");
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
        while (!req0_ready && n < TMO) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        while (!lcd_e && n < TMO) begin @(negedge clk); n++; end
        n_vec++;
        if (lcd_e !== 1'b1) begin
            n_mis++;
            $display("FAIL midreset E rise: got lcd_e=%b, required 1", lcd_e);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (lcd_e !== 1'b0)     begin n_mis++; $display("FAIL midreset lcd_e: got %b required 0", lcd_e); end
        if (lcd_data !== 8'h00) begin n_mis++; $display("FAIL midreset lcd_data: got %02h required 00", lcd_data); end
        if (init_done !== 1'b0) begin n_mis++; $display("FAIL midreset init_done: got %b required 0", init_done); end
        if (busy !== 1'b1)      begin n_mis++; $display("FAIL midreset busy: got %b required 1", busy); end
        $display("reset asserted during data write at cycle %0d", cyc);
        repeat (3) @(negedge clk);
        cap.delete();
        model_init();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_hi();
        test_wrap();
        test_clear_midline();
        test_back_to_back(6);
        test_random(30);
        test_reset_mid();
        test_init("reinit");
        test_hi();
        n_vec++;
        if (bad_cnt != 0) begin
            n_mis++;
            $display("FAIL ready outside idle: got %0d cycles, required 0", bad_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
